// File: rtl/alucodes.sv
// rtl/alucodes.sv - picoMIPS ALU function codes shared by the ALU and its control unit
package alucodes;
   localparam logic [2:0] RA   = 3'b000;
   localparam logic [2:0] RADD = 3'b010;
   localparam logic [2:0] RMUL = 3'b100;
endpackage

// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - picoMIPS control unit types, instruction field positions and decode helpers
package pm_pkg;
   import alucodes::*;

   localparam int PM_N = 8;
   localparam int PM_I = 20;
   localparam int PM_P = 6;

   // Field positions are offsets down from the instruction msb
   localparam int PM_OP_OFS  = 1;
   localparam int PM_RD_OFS  = 4;
   localparam int PM_RS_OFS  = 7;
   localparam int PM_OP_W    = 3;
   localparam int PM_REG_W   = 3;

   localparam logic [2:0] PM_FUNC_PASS = RA;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_ADDI = 3'b010,
      OP_MUL  = 3'b011,
      OP_MULI = 3'b100,
      OP_WAIT = 3'b101,
      OP_BZ   = 3'b110,
      OP_JMP  = 3'b111
   } pm_op_t;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_EXEC    = 3'd1,
      ST_WB      = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } pm_state_t;

   function automatic logic [2:0] pm_alu_func(input pm_op_t op);
      case (op)
         OP_ADD, OP_ADDI: return RADD;
         OP_MUL, OP_MULI: return RMUL;
         default:         return PM_FUNC_PASS;
      endcase
   endfunction

   function automatic logic pm_uses_imm(input pm_op_t op);
      return (op == OP_ADDI) || (op == OP_MULI);
   endfunction
endpackage

// File: rtl/pm_sync.sv
// rtl/pm_sync.sv - two-flop synchroniser for the asynchronous handshake button
module pm_sync (
   input  logic clk,
   input  logic n_reset,
   input  logic i_async,
   output logic o_sync
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;
endmodule

// File: rtl/pm_ctrl.sv
// rtl/pm_ctrl.sv - picoMIPS multi-cycle control unit: pc, instruction latch, decode, write-back, button wait
// Define PM_BRANCH_EN to enable the zero-flag branch (BZ); otherwise BZ behaves as NOP.
module pm_ctrl
   import pm_pkg::*;
#(
   parameter int n = PM_N,
   parameter int I = PM_I,
   parameter int P = PM_P
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [I-1:0] instr,
   input  logic         alu_zero,
   input  logic         btn,
   output logic [P-1:0] pc,
   output logic [2:0]   alu_func,
   output logic [2:0]   rs_addr,
   output logic [2:0]   rd_addr,
   output logic [n-1:0] imm,
   output logic         b_sel,
   output logic         a_sel,
   output logic         reg_we,
   output logic         waiting
);
   pm_state_t    r_state;
   pm_state_t    w_state_nxt;
   logic [I-1:0] r_ir;
   logic [P-1:0] r_pc;
   logic [P-1:0] w_pc_nxt;
   logic [P-1:0] w_pc_inc;
   logic [P-1:0] w_target;
   logic [2:0]   r_alu_func;
   logic [2:0]   r_rs;
   logic [2:0]   r_rd;
   logic         r_b_sel;
   logic         w_reg_we;
   logic         w_btn_s;
   logic         w_zf;
   logic         w_unused;
   pm_op_t       w_ir_op;
   pm_op_t       w_instr_op;

   assign w_ir_op    = pm_op_t'(r_ir[I-PM_OP_OFS -: PM_OP_W]);
   assign w_instr_op = pm_op_t'(instr[I-PM_OP_OFS -: PM_OP_W]);
   assign w_pc_inc   = r_pc + P'(1);
   assign w_target   = r_ir[P-1:0];

   pm_sync u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .i_async (btn),
      .o_sync  (w_btn_s)
   );

`ifdef PM_BRANCH_EN
   logic r_zf;

   // Only ALU instructions reach WB, so the flag tracks the last arithmetic result
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_zf <= 1'b0;
      end else if (r_state == ST_WB) begin
         r_zf <= alu_zero;
      end
   end

   assign w_zf     = r_zf;
   assign w_unused = &{1'b0, r_ir[I-PM_RD_OFS:n]};
`else
   assign w_zf     = 1'b0;
   assign w_unused = &{1'b0, alu_zero, r_ir[I-PM_RD_OFS:n]};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_reg_we    = 1'b0;
      case (r_state)
         ST_FETCH: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            case (w_ir_op)
               OP_ADD, OP_ADDI, OP_MUL, OP_MULI: w_state_nxt = ST_WB;
               OP_WAIT: w_state_nxt = ST_HOLD;
               OP_JMP: begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = ST_FETCH;
               end
               OP_BZ: begin
                  w_pc_nxt    = w_zf ? w_target : w_pc_inc;
                  w_state_nxt = ST_FETCH;
               end
               default: begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = ST_FETCH;
               end
            endcase
         end
         ST_WB: begin
            w_reg_we    = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_FETCH;
         end
         ST_HOLD: begin
            if (w_btn_s) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!w_btn_s) begin
               w_reg_we    = 1'b1;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   // Decode registers load with the instruction so they are valid from EXEC onward
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state    <= ST_FETCH;
         r_pc       <= '0;
         r_ir       <= '0;
         r_alu_func <= PM_FUNC_PASS;
         r_b_sel    <= 1'b0;
         r_rs       <= '0;
         r_rd       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (r_state == ST_FETCH) begin
            r_ir       <= instr;
            r_alu_func <= pm_alu_func(w_instr_op);
            r_b_sel    <= pm_uses_imm(w_instr_op);
            r_rs       <= instr[I-PM_RS_OFS -: PM_REG_W];
            r_rd       <= instr[I-PM_RD_OFS -: PM_REG_W];
         end
      end
   end

   assign pc       = r_pc;
   assign alu_func = r_alu_func;
   assign rs_addr  = r_rs;
   assign rd_addr  = r_rd;
   assign imm      = r_ir[n-1:0];
   assign b_sel    = r_b_sel;
   assign a_sel    = (r_state == ST_RELEASE);
   assign waiting  = (r_state == ST_HOLD) || (r_state == ST_RELEASE);
   // A reset cycle must never commit a register write
   assign reg_we   = w_reg_we & n_reset;
endmodule

// File: tb/tb_pm_ctrl.sv
// tb/tb_pm_ctrl.sv - self-checking bench for pm_ctrl with ROM, register file, ALU and ISA-level model
module tb_pm_ctrl;
   import alucodes::*;
   import pm_pkg::*;

`ifdef PM_BRANCH_EN
   localparam bit BRANCH_EN = 1'b1;
`else
   localparam bit BRANCH_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        n_reset;
   logic [19:0] instr;
   logic        alu_zero;
   logic        btn;
   logic [5:0]  pc;
   logic [2:0]  alu_func;
   logic [2:0]  rs_addr;
   logic [2:0]  rd_addr;
   logic [7:0]  imm;
   logic        b_sel;
   logic        a_sel;
   logic        reg_we;
   logic        waiting;

   int vectors = 0;
   int errors  = 0;

   logic [19:0] rom [64];
   logic [7:0]  regs [8] = '{default: 8'h00};
   logic [7:0]  switches;
   logic [7:0]  alu_a, alu_b, alu_y;
   logic signed [15:0] sa, sb, prod;

   logic [7:0] m_regs [8] = '{default: 8'h00};
   int         m_pc = 0;
   bit         m_zf = 1'b0;

   int          exp_cyc;
   bit          exp_we, exp_alu, exp_bsel;
   logic [2:0]  exp_addr, exp_func;
   logic [7:0]  exp_val;

   int          obs_we_cnt, obs_we_cyc;
   logic [2:0]  obs_addr, obs_func;
   logic [7:0]  obs_val;
   logic        obs_bsel;
   logic [5:0]  obs_pc;

   pm_ctrl dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .instr    (instr),
      .alu_zero (alu_zero),
      .btn      (btn),
      .pc       (pc),
      .alu_func (alu_func),
      .rs_addr  (rs_addr),
      .rd_addr  (rd_addr),
      .imm      (imm),
      .b_sel    (b_sel),
      .a_sel    (a_sel),
      .reg_we   (reg_we),
      .waiting  (waiting)
   );

   always #5 clk = ~clk;

   assign instr = rom[pc];

   always_comb begin
      alu_a = a_sel ? switches : regs[rs_addr];
      alu_b = b_sel ? imm : regs[rd_addr];
      sa    = {{8{alu_a[7]}}, alu_a};
      sb    = {{8{alu_b[7]}}, alu_b};
      prod  = sa * sb;
      case (alu_func)
         RADD:    alu_y = alu_a + alu_b;
         RMUL:    alu_y = prod[14:7];
         default: alu_y = alu_a;
      endcase
   end
   assign alu_zero = (alu_y == 8'h00);

   always @(posedge clk) if (reg_we) regs[rd_addr] <= alu_y;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [19:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] im);
      return {op, rd, rs, 3'b000, im};
   endfunction

   function automatic logic [7:0] q17(input logic [7:0] a, input logic [7:0] b);
      int x, y, p;
      x = (a > 8'd127) ? int'(a) - 256 : int'(a);
      y = (b > 8'd127) ? int'(b) - 256 : int'(b);
      p = (x * y) >>> 7;
      return p[7:0];
   endfunction

   task automatic model_step(input logic [19:0] w);
      logic [2:0] op, rd, rs;
      logic [7:0] im;
      op = w[19:17]; rd = w[16:14]; rs = w[13:11]; im = w[7:0];
      exp_we = 1'b0; exp_alu = 1'b0; exp_bsel = 1'b0; exp_cyc = 2;
      exp_func = PM_FUNC_PASS; exp_addr = rd; exp_val = 8'h00;
      case (op)
         3'd1: begin exp_val = m_regs[rd] + m_regs[rs]; exp_func = RADD; exp_alu = 1'b1; end
         3'd2: begin exp_val = m_regs[rs] + im; exp_func = RADD; exp_alu = 1'b1; exp_bsel = 1'b1; end
         3'd3: begin exp_val = q17(m_regs[rd], m_regs[rs]); exp_func = RMUL; exp_alu = 1'b1; end
         3'd4: begin exp_val = q17(m_regs[rs], im); exp_func = RMUL; exp_alu = 1'b1; exp_bsel = 1'b1; end
         default: ;
      endcase
      if (exp_alu) begin
         exp_we = 1'b1; exp_cyc = 3;
         m_regs[rd] = exp_val;
         m_zf = (exp_val == 8'h00);
         m_pc = (m_pc + 1) % 64;
      end else if (op == 3'd7 || (op == 3'd6 && BRANCH_EN && m_zf)) begin
         m_pc = int'(im[5:0]);
      end else begin
         m_pc = (m_pc + 1) % 64;
      end
   endtask

   task automatic run_dut(input int ncyc);
      obs_we_cnt = 0; obs_we_cyc = -1;
      for (int c = 0; c < ncyc; c++) begin
         if (c == 1) begin obs_func = alu_func; obs_bsel = b_sel; end
         if (reg_we) begin
            obs_we_cnt++; obs_we_cyc = c; obs_addr = rd_addr; obs_val = alu_y;
         end
         @(negedge clk);
      end
      obs_pc = pc;
   endtask

   task automatic do_instr(input logic [19:0] w);
      rom[m_pc] = w;
      model_step(w);
      run_dut(exp_cyc);
   endtask

   task automatic test_reset;
      n_reset = 1'b0; btn = 1'b0; switches = 8'h00;
      for (int i = 0; i < 64; i++) rom[i] = 20'h0;
      repeat (3) @(negedge clk);
      vectors++; if (pc !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
      vectors++; if (waiting !== 1'b0) begin errors++; $display("FAIL reset_waiting: got %b want 0", waiting); end
      vectors++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
      vectors++; if (a_sel !== 1'b0 || b_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got a=%b b=%b want 0 0", a_sel, b_sel); end
      vectors++; if (alu_func !== PM_FUNC_PASS) begin errors++; $display("FAIL reset_func: got %0d want %0d", alu_func, PM_FUNC_PASS); end
      vectors++; if (imm !== 8'h00 || rs_addr !== 3'd0 || rd_addr !== 3'd0) begin errors++; $display("FAIL reset_fields: got imm=%0h rs=%0d rd=%0d want 0", imm, rs_addr, rd_addr); end
      n_reset = 1'b1; m_pc = 0; m_zf = 1'b0;
   endtask

   task automatic test_addi;
      do_instr(enc(3'd2, 3'd1, 3'd0, 8'd5));
      vectors++; if (obs_func !== RADD || obs_bsel !== 1'b1) begin errors++; $display("FAIL addi_decode: got func=%0d bsel=%b want %0d 1", obs_func, obs_bsel, RADD); end
      vectors++; if (obs_we_cnt !== 1 || obs_we_cyc !== 2) begin errors++; $display("FAIL addi_we: got cnt=%0d cyc=%0d want 1 2", obs_we_cnt, obs_we_cyc); end
      vectors++; if (obs_pc !== 6'd1) begin errors++; $display("FAIL addi_pc: got %0d want 1", obs_pc); end
      vectors++; if (regs[1] !== 8'd5) begin errors++; $display("FAIL addi_r1: got %0h want 5", regs[1]); end
   endtask

   task automatic test_wait(input bit early, input logic [2:0] rd, input logic [7:0] sw);
      int start_pc, stray, cnt;
      bit seen, asel_at_we;
      logic [7:0] we_val;
      logic [2:0] we_addr;
      start_pc = m_pc; switches = sw; btn = early;
      rom[m_pc] = enc(3'd5, rd, 3'd0, 8'h00);
      run_dut(2);
      vectors++; if (obs_we_cnt !== 0 || waiting !== 1'b1) begin errors++; $display("FAIL wait_enter: got we=%0d waiting=%b want 0 1", obs_we_cnt, waiting); end
      btn = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (a_sel) seen = 1'b1; else @(negedge clk);
      end
      vectors++; if (!seen || waiting !== 1'b1) begin errors++; $display("FAIL wait_release: got a_sel=%b waiting=%b want 1 1", a_sel, waiting); end
      stray = 0;
      repeat ($urandom_range(0, 3)) begin
         if (reg_we) stray++;
         @(negedge clk);
      end
      btn = 1'b0; cnt = 0; seen = 1'b0; asel_at_we = 1'b0; we_val = 8'h00; we_addr = 3'd0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (reg_we) begin
            cnt++; seen = 1'b1; we_val = alu_y; we_addr = rd_addr; asel_at_we = a_sel;
         end
         @(negedge clk);
      end
      vectors++; if (cnt !== 1 || stray !== 0 || reg_we !== 1'b0) begin errors++; $display("FAIL wait_we: got pulses=%0d stray=%0d after=%b want 1 0 0", cnt, stray, reg_we); end
      vectors++; if (we_val !== sw || we_addr !== rd || asel_at_we !== 1'b1) begin errors++; $display("FAIL wait_data: got %0h@r%0d a_sel=%b want %0h@r%0d 1", we_val, we_addr, asel_at_we, sw, rd); end
      vectors++; if (pc !== 6'((start_pc + 1) % 64) || waiting !== 1'b0) begin errors++; $display("FAIL wait_exit: got pc=%0d waiting=%b want %0d 0", pc, waiting, (start_pc + 1) % 64); end
      vectors++; if (regs[rd] !== sw) begin errors++; $display("FAIL wait_reg: got %0h want %0h", regs[rd], sw); end
      m_regs[rd] = sw; m_pc = (m_pc + 1) % 64;
   endtask

   task automatic test_branch;
      int pc_before;
      do_instr(enc(3'd2, 3'd4, 3'd0, 8'd0));
      do_instr(enc(3'd1, 3'd4, 3'd0, 8'd0));
      vectors++; if (obs_val !== 8'h00) begin errors++; $display("FAIL bz_add0: got %0h want 0", obs_val); end
      test_wait(1'b0, 3'd5, 8'h2A);
      pc_before = m_pc;
      do_instr(enc(3'd6, 3'd0, 3'd0, 8'h10));
      vectors++; if (obs_pc !== (BRANCH_EN ? 6'h10 : 6'((pc_before + 1) % 64))) begin errors++; $display("FAIL bz_taken: got %0h from pc %0h", obs_pc, pc_before); end
      do_instr(enc(3'd2, 3'd5, 3'd0, 8'd1));
      do_instr(enc(3'd2, 3'd6, 3'd0, 8'd2));
      do_instr(enc(3'd1, 3'd5, 3'd6, 8'd0));
      vectors++; if (obs_val !== 8'h03) begin errors++; $display("FAIL bz_add3: got %0h want 3", obs_val); end
      pc_before = m_pc;
      do_instr(enc(3'd6, 3'd0, 3'd0, 8'h10));
      vectors++; if (obs_pc !== 6'((pc_before + 1) % 64)) begin errors++; $display("FAIL bz_not_taken: got %0h want %0h", obs_pc, (pc_before + 1) % 64); end
   endtask

   task automatic test_jmp_nop_wrap;
      do_instr(enc(3'd7, 3'd0, 3'd0, 8'h3F));
      vectors++; if (obs_pc !== 6'h3F || obs_we_cnt !== 0) begin errors++; $display("FAIL jmp_63: got pc=%0h we=%0d want 3f 0", obs_pc, obs_we_cnt); end
      do_instr(enc(3'd7, 3'd2, 3'd3, 8'hE5));
      vectors++; if (obs_pc !== 6'h25) begin errors++; $display("FAIL jmp_from_63: got %0h want 25", obs_pc); end
      do_instr(enc(3'd7, 3'd0, 3'd0, 8'h3F));
      do_instr(enc(3'd0, 3'd0, 3'd0, 8'h00));
      vectors++; if (obs_pc !== 6'h00 || obs_func !== PM_FUNC_PASS) begin errors++; $display("FAIL nop_wrap: got pc=%0h func=%0d want 0 %0d", obs_pc, obs_func, PM_FUNC_PASS); end
   endtask

   task automatic test_muli;
      int pc_before;
      do_instr(enc(3'd2, 3'd1, 3'd0, 8'h40));
      do_instr(enc(3'd4, 3'd3, 3'd1, 8'h40));
      vectors++; if (obs_func !== RMUL || obs_bsel !== 1'b1) begin errors++; $display("FAIL muli_decode: got func=%0d bsel=%b want %0d 1", obs_func, obs_bsel, RMUL); end
      vectors++; if (obs_val !== 8'h20 || regs[3] !== 8'h20) begin errors++; $display("FAIL muli_value: got we=%0h r3=%0h want 20", obs_val, regs[3]); end
      pc_before = m_pc;
      do_instr(enc(3'd6, 3'd0, 3'd0, 8'h10));
      vectors++; if (obs_pc !== 6'((pc_before + 1) % 64)) begin errors++; $display("FAIL muli_zf: got pc=%0h want %0h", obs_pc, (pc_before + 1) % 64); end
   endtask

   task automatic test_reset_mid(input int where);
      logic [7:0] keep;
      keep = m_regs[6]; btn = 1'b0; switches = 8'h99;
      rom[m_pc] = (where == 2) ? enc(3'd2, 3'd6, 3'd0, 8'h77) : enc(3'd5, 3'd6, 3'd0, 8'h00);
      run_dut(2);
      if (where == 1) begin
         btn = 1'b1;
         for (int c = 0; c < 8 && !a_sel; c++) @(negedge clk);
         btn = 1'b0;
         repeat (2) @(negedge clk);
      end
      n_reset = 1'b0;
      #1;
      vectors++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst%0d_we: got %b want 0", where, reg_we); end
      @(negedge clk);
      vectors++; if (pc !== 6'd0 || waiting !== 1'b0 || a_sel !== 1'b0) begin errors++; $display("FAIL rst%0d_state: got pc=%0h waiting=%b a_sel=%b want 0 0 0", where, pc, waiting, a_sel); end
      vectors++; if (regs[6] !== keep) begin errors++; $display("FAIL rst%0d_nowrite: got r6=%0h want %0h", where, regs[6], keep); end
      n_reset = 1'b1; m_pc = 0; m_zf = 1'b0;
   endtask

   task automatic test_random(input int count);
      logic [2:0]  op;
      logic [19:0] w;
      for (int k = 0; k < count; k++) begin
         do op = 3'($urandom_range(0, 7)); while (op == 3'd5);
         w = {op, 17'($urandom)};
         do_instr(w);
         vectors++; if (obs_pc !== 6'(m_pc)) begin errors++; $display("FAIL rnd_pc: instr %05h got %0h want %0h", w, obs_pc, m_pc); end
         vectors++; if (obs_we_cnt !== int'(exp_we)) begin errors++; $display("FAIL rnd_we: instr %05h got %0d want %0d", w, obs_we_cnt, exp_we); end
         vectors++; if (obs_func !== exp_func) begin errors++; $display("FAIL rnd_func: instr %05h got %0d want %0d", w, obs_func, exp_func); end
         if (exp_we) begin
            vectors++; if (obs_addr !== exp_addr || obs_val !== exp_val) begin errors++; $display("FAIL rnd_wb: instr %05h got %0h@r%0d want %0h@r%0d", w, obs_val, obs_addr, exp_val, exp_addr); end
            vectors++; if (obs_bsel !== exp_bsel) begin errors++; $display("FAIL rnd_bsel: instr %05h got %b want %b", w, obs_bsel, exp_bsel); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_addi;
      test_wait(1'b0, 3'd2, 8'h2A);
      test_wait(1'b1, 3'd7, 8'hC3);
      test_branch;
      test_jmp_nop_wrap;
      test_muli;
      test_reset_mid(0);
      test_reset_mid(1);
      test_reset_mid(2);
      test_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
